// File: rtl/prod_track_pkg.sv
// rtl/prod_track_pkg.sv - shared constants and types for the product-track reader
package prod_track_pkg;

    localparam int WORD_BITS_C  = 29;
    localparam int TRACK_BITS_C = 2 * WORD_BITS_C;

    typedef enum logic [1:0] {SEL_ID, SEL_MQ, SEL_PN, SEL_BAD} track_sel_e;

    typedef enum logic [1:0] {RDR_IDLE, RDR_ARM, RDR_SHIFT, RDR_HOLD} rdr_state_e;

endpackage

// File: rtl/track_deser.sv
// rtl/track_deser.sv - serial-in/parallel-out capture register with bit counter and done flag
module track_deser
    import prod_track_pkg::*;
#(
    parameter int BITS = TRACK_BITS_C
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr_i,
    input  logic            en_i,
    input  logic            bit_i,
    output logic [BITS-1:0] data_o,
    output logic            done_o
);

    localparam int CNT_W = $clog2(BITS);

    logic [BITS-1:0]  sr_q;
    logic [CNT_W-1:0] cnt_q;

    // data_o already carries the bit being sampled this clock, so the final
    // image is available on the same edge that samples the last bit.
    always_comb begin
        data_o        = sr_q;
        data_o[cnt_q] = bit_i;
    end

    assign done_o = en_i && (cnt_q == CNT_W'(BITS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (clr_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else if (en_i) begin
            sr_q  <= data_o;
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/prod_track_reader.sv
// rtl/prod_track_reader.sv - snooping read-out port for the ID/MQ/PN product tracks
// Optional two's-complement view enabled by PROD_TRACK_READER_TWOS_EN.
module prod_track_reader
    import prod_track_pkg::*;
#(
    parameter int TRACK_BITS   = TRACK_BITS_C,
    parameter int SYNC_TIMEOUT = 128
) (
    input  logic                  CLOCK,
    input  logic                  rst_n,
    input  logic                  T0,
    input  logic                  CE,
    input  logic                  PI,
    input  logic                  PR,
    input  logic                  PP,
    input  logic                  req_valid,
    input  logic [1:0]            req_sel,
    output logic                  req_ready,
    output logic                  rsp_valid,
    output logic [TRACK_BITS-1:0] rsp_data,
    output logic                  rsp_err,
    input  logic                  rsp_ready,
    output logic [TRACK_BITS-1:0] rsp_twos
);

    localparam int TMO_W = $clog2(SYNC_TIMEOUT);

    rdr_state_e            state_q, state_d;
    track_sel_e            sel_q, sel_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [TRACK_BITS-1:0] rsp_data_q, rsp_data_d;
    logic                  track_bit, des_en, des_clr, des_done;
    logic [TRACK_BITS-1:0] des_data;

    always_comb begin
        unique case (sel_q)
            SEL_ID:  track_bit = PI;
            SEL_MQ:  track_bit = PR;
            SEL_PN:  track_bit = PP;
            default: track_bit = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        tmo_d      = tmo_q;
        rsp_err_d  = rsp_err_q;
        rsp_data_d = rsp_data_q;
        des_en     = 1'b0;
        unique case (state_q)
            RDR_IDLE: begin
                if (req_valid) begin
                    if (track_sel_e'(req_sel) == SEL_BAD) begin
                        state_d    = RDR_HOLD;
                        rsp_err_d  = 1'b1;
                        rsp_data_d = '0;
                    end else begin
                        sel_d   = track_sel_e'(req_sel);
                        state_d = RDR_ARM;
                    end
                end
            end
            RDR_ARM: begin
                if (T0 && CE) begin
                    des_en  = 1'b1;
                    state_d = RDR_SHIFT;
                end else if (tmo_q == TMO_W'(SYNC_TIMEOUT - 1)) begin
                    state_d    = RDR_HOLD;
                    rsp_err_d  = 1'b1;
                    rsp_data_d = '0;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            RDR_SHIFT: begin
                des_en = 1'b1;
                if (des_done) begin
                    state_d    = RDR_HOLD;
                    rsp_err_d  = 1'b0;
                    rsp_data_d = des_data;
                end
            end
            RDR_HOLD: begin
                if (rsp_ready) state_d = RDR_IDLE;
            end
            default: state_d = RDR_IDLE;
        endcase
        if (state_d != state_q) tmo_d = '0;
    end

    // ARM->SHIFT keeps the counter at 1 from the first sample; every other entry clears it.
    assign des_clr = (state_d != state_q) && (state_d != RDR_SHIFT);

    track_deser #(
        .BITS (TRACK_BITS)
    ) u_deser (
        .clk    (CLOCK),
        .rst_n  (rst_n),
        .clr_i  (des_clr),
        .en_i   (des_en),
        .bit_i  (track_bit),
        .data_o (des_data),
        .done_o (des_done)
    );

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RDR_IDLE;
            sel_q      <= SEL_ID;
            tmo_q      <= '0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            tmo_q      <= tmo_d;
            rsp_err_q  <= rsp_err_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready = (state_q == RDR_IDLE);
    assign rsp_valid = (state_q == RDR_HOLD);
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;

`ifdef PROD_TRACK_READER_TWOS_EN
    logic [TRACK_BITS-1:0] twos_q, twos_d, mag;

    // Image is sign-magnitude with the sign in the first (LSB) bit.
    always_comb begin
        mag    = {1'b0, des_data[TRACK_BITS-1:1]};
        twos_d = twos_q;
        if (state_q != RDR_HOLD && state_d == RDR_HOLD)
            twos_d = rsp_err_d ? '0 : (des_data[0] ? (-mag) : mag);
    end

    always_ff @(posedge CLOCK or negedge rst_n) begin
        if (!rst_n) twos_q <= '0;
        else        twos_q <= twos_d;
    end

    assign rsp_twos = twos_q;
`else
    assign rsp_twos = '0;
`endif

endmodule

// File: tb/tb_prod_track_reader.sv
// tb/tb_prod_track_reader.sv - directed scoreboard bench for prod_track_reader
module tb_prod_track_reader;

    logic        CLOCK = 1'b0;
    logic        rst_n = 1'b1;
    logic        T0 = 1'b0, CE = 1'b0, PI = 1'b0, PR = 1'b0, PP = 1'b0;
    logic        req_valid = 1'b0;
    logic [1:0]  req_sel = 2'd0;
    logic        req_ready, rsp_valid, rsp_err;
    logic        rsp_ready = 1'b0;
    logic [57:0] rsp_data, rsp_twos;

    typedef struct packed {
        logic        err;
        logic [57:0] data;
        logic [57:0] twos;
    } rsp_t;

    rsp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

`ifdef PROD_TRACK_READER_TWOS_EN
    localparam bit TWOS_ON = 1'b1;
`else
    localparam bit TWOS_ON = 1'b0;
`endif

    prod_track_reader dut (
        .CLOCK     (CLOCK),
        .rst_n     (rst_n),
        .T0        (T0),
        .CE        (CE),
        .PI        (PI),
        .PR        (PR),
        .PP        (PP),
        .req_valid (req_valid),
        .req_sel   (req_sel),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .rsp_ready (rsp_ready),
        .rsp_twos  (rsp_twos)
    );

    always #5 CLOCK = ~CLOCK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [57:0] twos_of(input logic [57:0] img);
        logic [57:0] m;
        m = {1'b0, img[57:1]};
        if (!TWOS_ON) return 58'd0;
        return img[0] ? (58'd0 - m) : m;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge CLOCK);
    endtask

    task automatic push(input logic err, input logic [57:0] data);
        rsp_t e;
        e.err  = err;
        e.data = data;
        e.twos = err ? 58'd0 : twos_of(data);
        exp_q.push_back(e);
    endtask

    task automatic drive_tracks(input int sel, input logic b);
        PI = (sel == 0) ? b : ~b;
        PR = (sel == 1) ? b : ~b;
        PP = (sel == 2) ? b : ~b;
    endtask

    task automatic request(input logic [1:0] sel);
        req_valid = 1'b1;
        req_sel   = sel;
        chk("req_ready_accept", {63'd0, req_ready}, 64'd1);
        step();
        req_valid = 1'b0;
    endtask

    // Track bits follow the drum order; spurious T0/CE pulses mid-image must be ignored.
    task automatic send_image(input int sel, input logic [57:0] img, input int lead, input int nbits);
        for (int i = 0; i < lead; i++) begin
            T0 = 1'b0;
            CE = 1'b0;
            drive_tracks(sel, 1'($urandom_range(0, 1)));
            step();
        end
        for (int k = 0; k < nbits; k++) begin
            T0 = (k == 0) || (k == 10) || (k == 29);
            CE = (k < 29);
            drive_tracks(sel, img[k]);
            if (k == 57) chk("valid_before_last_bit", {63'd0, rsp_valid}, 64'd0);
            step();
        end
        T0 = 1'b0;
        CE = 1'b0;
    endtask

    task automatic take_rsp(input int hold);
        rsp_t        e;
        logic [57:0] d0;
        chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=response expected=none");
            return;
        end
        e  = exp_q.pop_front();
        d0 = rsp_data;
        repeat (hold) step();
        if (hold > 0) begin
            chk("hold_data_stable", {6'd0, rsp_data}, {6'd0, d0});
            chk("hold_valid_stable", {63'd0, rsp_valid}, 64'd1);
        end
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_sel   = 2'd3;
        chk("req_ready_in_hold", {63'd0, req_ready}, 64'd0);
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
        chk("rsp_data", {6'd0, rsp_data}, {6'd0, e.data});
        chk("rsp_twos", {6'd0, rsp_twos}, {6'd0, e.twos});
        step();
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        chk("rsp_valid_drop", {63'd0, rsp_valid}, 64'd0);
        chk("req_ready_idle", {63'd0, req_ready}, 64'd1);
        chk("rsp_data_kept", {6'd0, rsp_data}, {6'd0, e.data});
    endtask

    initial begin
        int n;

        #2 rst_n = 1'b0;
        step();
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        chk("rst_rsp_data", {6'd0, rsp_data}, 64'd0);
        chk("rst_rsp_twos", {6'd0, rsp_twos}, 64'd0);
        rst_n = 1'b1;
        step();

        push(1'b0, 58'h0A5);
        request(2'd1);
        send_image(1, 58'h0A5, 10, 58);
        take_rsp(0);

        push(1'b1, 58'd0);
        T0 = 1'b0;
        CE = 1'b0;
        request(2'd3);
        chk("bad_sel_valid_next", {63'd0, rsp_valid}, 64'd1);
        chk("bad_sel_err", {63'd0, rsp_err}, 64'd1);
        take_rsp(0);

        push(1'b1, 58'd0);
        request(2'd0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            step();
            n++;
        end
        chk("timeout_latency", 64'(n), 64'd128);
        take_rsp(0);

        push(1'b0, 58'h2AAAAAAAAAAAAAA);
        T0 = 1'b1;
        CE = 1'b1;
        drive_tracks(0, 1'b1);
        request(2'd0);
        send_image(0, 58'h2AAAAAAAAAAAAAA, 3, 58);
        take_rsp(0);

        request(2'd2);
        send_image(2, 58'h155555555555555, 2, 30);
        chk("data_before_rst", {6'd0, rsp_data}, {6'd0, 58'h2AAAAAAAAAAAAAA});
        rst_n = 1'b0;
        #1;
        chk("async_rst_data", {6'd0, rsp_data}, 64'd0);
        chk("async_rst_valid", {63'd0, rsp_valid}, 64'd0);
        chk("async_rst_ready", {63'd0, req_ready}, 64'd1);
        step();
        rst_n = 1'b1;
        step();
        push(1'b0, 58'h123456789ABCDEF);
        request(2'd2);
        send_image(2, 58'h123456789ABCDEF, 5, 58);
        take_rsp(0);

        exp_q.push_back({1'b0, 58'h0B, TWOS_ON ? 58'h3FFFFFFFFFFFFFB : 58'd0});
        request(2'd2);
        send_image(2, 58'h0B, 4, 58);
        take_rsp(20);

        exp_q.push_back({1'b0, 58'h01, 58'd0});
        request(2'd2);
        send_image(2, 58'h01, 1, 58);
        take_rsp(0);

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prod_track_reader.md
Name: prod_track_reader

Overview:
- Non-intrusive read-out port for the serial product-register tracks (ID, MQ, PN). These tracks are written serially by the product gates.
- The block snoops the recirculating track outputs. It is the reader side of those writers.
- It captures one full double-precision (58-bit, even+odd word) image of a selected register, bit-serially, on request.
- It hands the image to a host/debug client through a valid/ready handshake. It never drives any track or bus.

Parameters:
- TRACK_BITS, 58, bits per double-precision register image (2 x 29).
- SYNC_TIMEOUT, 128, clocks allowed in ARM waiting for even-word T0 before an error response.

Ports:
- CLOCK  in  1  system clock; one clock = one bit time.
- rst_n  in  1  asynchronous, active-low reset.
- T0  in  1  bit-time-0 strobe, high for one clock at the start of every word.
- CE  in  1  high for the whole of each even word time.
- PI  in  1  ID track serial output.
- PR  in  1  MQ track serial output.
- PP  in  1  PN track serial output.
- req_valid  in  1  capture request.
- req_sel  in  2  0 = ID, 1 = MQ, 2 = PN, 3 = illegal.
- req_ready  out  1  block can accept a request.
- rsp_valid  out  1  response available.
- rsp_data  out  58  captured image; bit 0 = first bit (even word T0).
- rsp_err  out  1  response is an error (illegal select or sync timeout).
- rsp_ready  in  1  client accepts response.
- rsp_twos  out  58  two's-complement view (see Optional Feature).

Behaviour:
- Reset (async assert, sync deassert is the integrator's job). State = IDLE. req_ready=1. rsp_valid=0, rsp_err=0, rsp_data=0, rsp_twos=0. Bit counter and timeout counter = 0.
- IDLE: req_ready=1.
  - req_valid&req_ready with sel 0..2: latch sel, go to ARM.
  - req_valid&req_ready with sel 3: go to HOLD with rsp_err=1, rsp_data=0. rsp_valid is high the next clock.
- ARM: req_ready=0. Timeout counter increments each clock.
  - On a clock with T0&CE: sample the selected track into bit 0, set bit counter=1, go to SHIFT.
  - T0&CE on the acceptance clock itself is ignored. Capture starts at the next qualifying T0, up to one drum revolution later.
  - Timeout counter reaching SYNC_TIMEOUT-1 without sync: go to HOLD with rsp_err=1, rsp_data=0.
- SHIFT: each clock, sample the selected track into bit[counter] and increment the counter.
  - T0 and CE are ignored while shifting.
  - After bit 57 is sampled (counter==57), go to HOLD with rsp_err=0.
  - Total capture latency = 58 clocks from the first sample.
- HOLD: rsp_valid=1. rsp_data and rsp_err are stable.
  - On rsp_valid&rsp_ready: go to IDLE. rsp_valid drops the next clock. rsp_data holds its last value.
  - No new request is accepted until IDLE (req_ready=0 in HOLD), including on the handshake clock.
- Selected track is muxed combinationally from PI/PR/PP. The sample is registered on the CLOCK edge, consistent with the sr_ff and drum_track timing.
- rst_n asserted mid-ARM, mid-SHIFT or mid-HOLD: immediate return to reset state. The pending response is discarded.
- Counters are 6-bit (bit) and $clog2(SYNC_TIMEOUT)-bit (timeout). Both clear on every state entry.

Optional Feature:
- Macro: PROD_TRACK_READER_TWOS_EN.
- Defined: on entry to HOLD (non-error), register rsp_twos from the image. Sign = rsp_data[0]; magnitude = {1'b0, rsp_data[57:1]} (57-bit magnitude, zero-extended to 58 bits).
  - rsp_twos = sign ? -magnitude (58-bit wrap) : magnitude.
  - Minus zero (sign=1, magnitude=0) yields 0.
  - On error, rsp_twos=0.
- Undefined: rsp_twos is tied to 0 and no conversion logic exists. The port is retained.

Decomposition:
- Package prod_track_pkg:
  - TRACK_BITS_C = 58 and WORD_BITS_C = 29.
  - Enum track_sel_e {SEL_ID, SEL_MQ, SEL_PN, SEL_BAD}.
  - Enum rdr_state_e {RDR_IDLE, RDR_ARM, RDR_SHIFT, RDR_HOLD}.
- One sub-module: track_deser. It holds the serial-in/parallel-out register, the bit counter and the done flag, with enable/clear inputs. The FSM, timeout counter, handshake and optional conversion stay in the top.

Test Plan:
- PR track preloaded with 58'h0000_0000_0000_0A5. Request sel=1. T0&CE arrives 10 clocks later. Expected: rsp_valid 58 clocks after the first sample, rsp_data=58'h0A5, rsp_err=0.
- Request with sel=3. Expected: rsp_valid the next clock, rsp_err=1, rsp_data=0, with no wait for T0.
- sel=0 with T0 held low for 200 clocks (SYNC_TIMEOUT=128). Expected: rsp_err=1 exactly 128 clocks after acceptance.
- Request accepted on a clock where T0&CE=1. Expected: that sync is ignored and capture aligns with the next even-word T0; check bit 0 is from the later word.
- rst_n pulsed low mid-SHIFT (counter=30). Expected: outputs zero asynchronously and req_ready=1. A fresh sel=2 capture then completes correctly.
- With TWOS_EN, PP image {magnitude 5, sign 1} = 58'h0B. Expected: rsp_twos = 58'h3FF_FFFF_FFFF_FFFB. Minus zero 58'h01 gives rsp_twos=0. Hold rsp_ready low for 20 clocks and check rsp_data stays stable.
